ifu: RTL and testbench

- Instruction fetch unit: the transmitter feeding the decode stage over the valid/ready stage handshake.
- Generates the PC, fetches one instruction at a time from the instruction memory port, and buffers it in an output register.
- Presents instruction and PC to decode; applies branch/jump redirects from the branch unit.
- Marks wrong-path transfers with a nop flag so decode substitutes ADDI x0,x0,0.

---
 rtl/ifu.sv | 109 ++++++++++
 tb/tb_ifu.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: a single-outstanding-request fetcher that feeds decode
// over a valid/ready handshake and follows redirects from the branch unit.
module ifu #(
  parameter int unsigned           CPU_WIDTH = 64,
  parameter int unsigned           INS_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0]  RESET_PC  = 64'h8000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  // Instruction memory port
  output logic                 o_imem_req,
  output logic [CPU_WIDTH-1:0] o_imem_addr,
  input  logic                 i_imem_gnt,
  input  logic                 i_imem_rvalid,
  input  logic [INS_WIDTH-1:0] i_imem_rdata,
  // Branch unit redirect
  input  logic                 i_bru_jmp,
  input  logic [CPU_WIDTH-1:0] i_bru_pc,
  // Decode stage
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  output logic [INS_WIDTH-1:0] o_ifu_ins,
  output logic [CPU_WIDTH-1:0] o_ifu_pc,
  output logic                 o_ifu_nop
);

  localparam logic [CPU_WIDTH-1:0] PcStep = CPU_WIDTH'(4);
  localparam logic [INS_WIDTH-1:0] NopIns = INS_WIDTH'(32'h13);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e               state;
  logic [CPU_WIDTH-1:0] fetch_pc;
  // Set when the outstanding response belongs to a path abandoned by a redirect.
  logic                 kill;

  // The address register is the fetch PC itself, so a redirect in REQ retargets
  // the pending request before it is granted.
  assign o_imem_addr = fetch_pc;

  // Any transfer in a redirect cycle is from the wrong path.
  assign o_ifu_nop = o_post_valid & i_bru_jmp;

  // Fetch FSM with registered request and decode-side outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= StIdle;
      fetch_pc     <= RESET_PC;
      kill         <= 1'b0;
      o_imem_req   <= 1'b0;
      o_post_valid <= 1'b0;
      o_ifu_ins    <= NopIns;
      o_ifu_pc     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (i_bru_jmp) fetch_pc <= i_bru_pc;
          state      <= StReq;
          o_imem_req <= 1'b1;
        end
        StReq: begin
          if (i_imem_gnt) begin
            state      <= StWait;
            o_imem_req <= 1'b0;
            if (i_bru_jmp) begin
              fetch_pc <= i_bru_pc;
              kill     <= 1'b1;
            end
          end else if (i_bru_jmp) begin
            fetch_pc <= i_bru_pc;
          end
        end
        StWait: begin
          if (i_imem_rvalid) begin
            if (kill || i_bru_jmp) begin
              // Wrong-path data: drop it and refetch from the current target.
              kill       <= 1'b0;
              state      <= StReq;
              o_imem_req <= 1'b1;
              if (i_bru_jmp) fetch_pc <= i_bru_pc;
            end else begin
              o_ifu_ins    <= i_imem_rdata;
              o_ifu_pc     <= fetch_pc;
              o_post_valid <= 1'b1;
              fetch_pc     <= fetch_pc + PcStep;
              state        <= StHold;
            end
          end else if (i_bru_jmp) begin
            fetch_pc <= i_bru_pc;
            kill     <= 1'b1;
          end
        end
        StHold: begin
          if (i_bru_jmp || i_post_ready) begin
            if (i_bru_jmp) fetch_pc <= i_bru_pc;
            o_post_valid <= 1'b0;
            state        <= StReq;
            o_imem_req   <= 1'b1;
          end
        end
        default: begin
          state      <= StIdle;
          o_imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios followed by a randomized run checked against
// a transaction-level model of the fetch stream.
module tb_ifu;

  localparam int unsigned CW = 64;
  localparam int unsigned IW = 32;
  localparam logic [CW-1:0] RST_PC = 64'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [CW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          bru_jmp;
  logic [CW-1:0] bru_pc;
  logic          post_valid;
  logic          post_ready;
  logic [IW-1:0] ifu_ins;
  logic [CW-1:0] ifu_pc;
  logic          ifu_nop;

  int n_cmp = 0;
  int n_err = 0;

  ifu #(.CPU_WIDTH(CW), .INS_WIDTH(IW), .RESET_PC(RST_PC)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_gnt   (imem_gnt),
    .i_imem_rvalid(imem_rvalid),
    .i_imem_rdata (imem_rdata),
    .i_bru_jmp    (bru_jmp),
    .i_bru_pc     (bru_pc),
    .o_post_valid (post_valid),
    .i_post_ready (post_ready),
    .o_ifu_ins    (ifu_ins),
    .o_ifu_pc     (ifu_pc),
    .o_ifu_nop    (ifu_nop)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    bru_jmp = 0; bru_pc = '0; post_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (post_valid !== 1'b0 || imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: valid=%b req=%b, required 0/0", i, post_valid, imem_req);
      end
    end
    n_cmp++;
    if (imem_addr !== RST_PC || ifu_ins !== 32'h13 || ifu_pc !== '0 || ifu_nop !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: addr=%h ins=%h pc=%h nop=%b, required %h/00000013/0/0",
               imem_addr, ifu_ins, ifu_pc, ifu_nop, RST_PC);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      n_err++;
      $display("FAIL reset_first_req: req=%b addr=%h, required 1/%h", imem_req, imem_addr, RST_PC);
    end
  endtask

  // Entered with the DUT in REQ; leaves it in REQ at pc+4.
  task automatic test_straight();
    logic [IW-1:0] data [3];
    logic [CW-1:0] pc;
    data[0] = 32'h0000_0013; data[1] = 32'h0010_0093; data[2] = 32'h0020_0113;
    pc = RST_PC;
    post_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== pc) begin
        n_err++;
        $display("FAIL straight_req%0d: req=%b addr=%h, required 1/%h", i, imem_req, imem_addr, pc);
      end
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data[i];
      @(negedge clk);
      imem_rvalid = 1'b0;
      n_cmp++;
      if (post_valid !== 1'b1 || ifu_ins !== data[i] || ifu_pc !== pc || ifu_nop !== 1'b0) begin
        n_err++;
        $display("FAIL straight_xfer%0d: valid=%b ins=%h pc=%h nop=%b, required 1/%h/%h/0",
                 i, post_valid, ifu_ins, ifu_pc, ifu_nop, data[i], pc);
      end
      @(negedge clk);
      pc = pc + 4;
    end
    n_cmp++;
    if (post_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== pc) begin
      n_err++;
      $display("FAIL straight_end: valid=%b req=%b addr=%h, required 0/1/%h",
               post_valid, imem_req, imem_addr, pc);
    end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] pc;
    pc = 64'h8000_000C;
    post_ready = 1'b0;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0030_0193;
    @(negedge clk);
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (post_valid !== 1'b1 || ifu_ins !== 32'h0030_0193 || ifu_pc !== pc || imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b ins=%h pc=%h req=%b, required 1/00300193/%h/0",
                 i, post_valid, ifu_ins, ifu_pc, imem_req, pc);
      end
      @(negedge clk);
    end
    post_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (post_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== pc + 4) begin
      n_err++;
      $display("FAIL bp_release: valid=%b req=%b addr=%h, required 0/1/%h",
               post_valid, imem_req, imem_addr, pc + 4);
    end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; bru_jmp = 1'b1; bru_pc = 64'h8000_1000;
    @(negedge clk);
    bru_jmp = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (post_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h8000_1000) begin
        n_err++;
        $display("FAIL redir_wait%0d: valid=%b req=%b addr=%h, required 0/1/80001000",
                 i, post_valid, imem_req, imem_addr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_hold();
    post_ready = 1'b0;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    @(negedge clk);
    imem_rvalid = 1'b0;
    post_ready = 1'b1; bru_jmp = 1'b1; bru_pc = 64'h8000_2000;
    #1;
    n_cmp++;
    if (post_valid !== 1'b1 || ifu_nop !== 1'b1) begin
      n_err++;
      $display("FAIL redir_hold_nop: valid=%b nop=%b, required 1/1", post_valid, ifu_nop);
    end
    @(negedge clk);
    bru_jmp = 1'b0;
    n_cmp++;
    if (post_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h8000_2000) begin
      n_err++;
      $display("FAIL redir_hold_req: valid=%b req=%b addr=%h, required 0/1/80002000",
               post_valid, imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    @(negedge clk);
    imem_rvalid = 1'b0;
    n_cmp++;
    if (post_valid !== 1'b1 || ifu_nop !== 1'b0 || ifu_pc !== 64'h8000_2000 ||
        ifu_ins !== 32'h2222_2222) begin
      n_err++;
      $display("FAIL redir_hold_next: valid=%b nop=%b pc=%h ins=%h, required 1/0/80002000/22222222",
               post_valid, ifu_nop, ifu_pc, ifu_ins);
    end
    @(negedge clk);
  endtask

  task automatic test_jmp_gnt_reset();
    imem_gnt = 1'b1; bru_jmp = 1'b1; bru_pc = 64'h8000_3000;
    @(negedge clk);
    imem_gnt = 1'b0; bru_jmp = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== RST_PC || post_valid !== 1'b0 ||
        ifu_ins !== 32'h13 || ifu_pc !== '0 || ifu_nop !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: req=%b addr=%h valid=%b ins=%h pc=%h nop=%b, required reset values",
               imem_req, imem_addr, post_valid, ifu_ins, ifu_pc, ifu_nop);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      n_err++;
      $display("FAIL mid_reset_req: req=%b addr=%h, required 1/%h", imem_req, imem_addr, RST_PC);
    end
  endtask

  // Model tracks the architectural fetch stream: the next expected address, the
  // one request in flight (and whether a redirect orphaned it), and the held word.
  task automatic test_random();
    logic [CW-1:0] exp_pc, pend_addr, held_pc;
    logic [IW-1:0] held_ins;
    logic pend, pend_dead, held_v;
    int   pend_dly, xfers;
    exp_pc = RST_PC; pend = 0; pend_dead = 0; held_v = 0; pend_dly = 0; xfers = 0;
    held_pc = '0; held_ins = '0; pend_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (post_valid !== held_v || (held_v && (ifu_ins !== held_ins || ifu_pc !== held_pc))) begin
        n_err++;
        $display("FAIL rand_out cyc%0d: valid=%b ins=%h pc=%h, required %b/%h/%h",
                 cyc, post_valid, ifu_ins, ifu_pc, held_v, held_ins, held_pc);
      end
      if (imem_req === 1'b1 && (pend || held_v)) begin
        n_err++;
        $display("FAIL rand_req cyc%0d: req=1 while busy, required 0", cyc);
      end
      post_ready = ($urandom_range(0, 2) != 0);
      imem_gnt   = ($urandom_range(0, 2) != 0);
      imem_rdata = $urandom;
      if (pend) begin
        imem_rvalid = (pend_dly == 0);
        if (pend_dly > 0) pend_dly--;
      end else begin
        imem_rvalid = ($urandom_range(0, 9) == 0);
      end
      bru_jmp = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       bru_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        1:       bru_pc = {32'h0, $urandom};
        default: bru_pc = RST_PC + {48'h0, 4'h0, $urandom_range(0, 4095) * 4};
      endcase
      #1;
      n_cmp++;
      if (ifu_nop !== (held_v & bru_jmp)) begin
        n_err++;
        $display("FAIL rand_nop cyc%0d: nop=%b, required %b", cyc, ifu_nop, held_v & bru_jmp);
      end
      if (held_v && (post_ready || bru_jmp)) begin
        held_v = 0;
        if (post_ready && !bru_jmp) xfers++;
      end
      if (imem_rvalid && pend) begin
        pend = 0;
        if (!pend_dead && !bru_jmp) begin
          held_v = 1; held_pc = pend_addr; held_ins = imem_rdata;
        end
      end
      if (imem_req === 1'b1 && imem_gnt) begin
        n_cmp++;
        if (imem_addr !== exp_pc) begin
          n_err++;
          $display("FAIL rand_addr cyc%0d: addr=%h, required %h", cyc, imem_addr, exp_pc);
        end
        pend = 1; pend_dead = 0; pend_addr = exp_pc; exp_pc = exp_pc + 4;
        pend_dly = $urandom_range(0, 3);
      end
      if (bru_jmp) begin
        exp_pc = bru_pc;
        if (pend) pend_dead = 1;
      end
    end
    n_cmp++;
    if (xfers < 50) begin
      n_err++;
      $display("FAIL rand_progress: transfers=%0d, required >= 50", xfers);
    end
    imem_gnt = 0; imem_rvalid = 0; bru_jmp = 0; post_ready = 0;
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_jmp_gnt_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
